sample_delay_line: RTL and testbench
====================================

Name: sample_delay_line

Overview:
- Upstream data stage of the serial FIR datapath. It captures incoming samples into a circular Num_coef-deep delay line and issues a one-cycle start pulse to the FIR controller.
- It returns the tap sample selected by the controller's tap address, registered, so the sample and the coefficient-ROM word reach the MAC on the same cycle.
- It buffers one sample that arrives while a filter pass is running and flags overruns.

Parameters:
- Num_coef, 17, number of taps and depth of the delay line.
- Data_width, 12, signed sample width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- val_in  in  1  new input sample valid, one-cycle qualifier.
- data_in  in  Data_width  signed input sample.
- addr  in  log2(Num_coef)  tap index from the controller; 0 = newest sample.
- done_in  in  1  filter-pass complete, the controller's val_out.
- overrun_clr  in  1  clears the overrun flag.
- data_out  out  Data_width  registered tap sample x[n-addr].
- val_start  out  1  one-cycle start pulse; drives the controller's val_in.
- busy  out  1  a filter pass is in progress.
- pending  out  1  one sample is held waiting for the current pass to end.
- overrun  out  1  sticky flag: a held sample was overwritten.

Behaviour:
- Reset (rst=0, asynchronous):
  - All Num_coef entries cleared to 0.
  - wr_ptr=0, newest=Num_coef-1.
  - data_out=0, val_start=0, busy=0, pending=0, overrun=0.
  - Reset mid-pass aborts the pass and discards any held sample.
- Commit event at a clock edge (happens when busy=0 and a sample is available):
  - Sample source: the held sample if pending=1, else data_in if val_in=1.
  - mem[wr_ptr] <= sample, newest <= wr_ptr.
  - wr_ptr <= wr_ptr+1, wrapping from Num_coef-1 to 0.
  - busy <= 1, val_start <= 1 for exactly one cycle.
- busy clears at the edge where done_in=1. No commit occurs at that same edge because busy is still 1 there, so the earliest next val_start is 2 cycles after done_in.
- Held-sample rules:
  - val_in=1 with busy=1: data_in goes to the hold register, pending <= 1.
  - val_in=1 with pending=1 and busy=1: the hold register is overwritten (newest sample wins), overrun <= 1.
  - val_in=1 with busy=0 and pending=1: the held sample commits and data_in becomes the new held sample; pending stays 1, no overrun.
  - The held sample commits at the first edge with busy=0; pending <= 0 unless refilled at that edge.
- overrun: set has priority over overrun_clr when both occur in the same cycle. It clears only on overrun_clr or reset.
- Read path:
  - Index = (newest - addr) mod Num_coef, computed without a divider: if addr > newest then newest - addr + Num_coef, else newest - addr.
  - data_out is registered every cycle, giving 1-cycle latency from addr.
  - addr >= Num_coef is out of range; data_out <= 0.
- Write/read same cycle: the read uses the memory content before the edge's write. Only the not-busy commit writes, so no hazard arises during a pass.
- There is no explicit FSM. State is carried by busy and pending:
  - IDLE (busy=0, pending=0)
  - RUN (busy=1, pending=0)
  - RUN_HELD (busy=1, pending=1)
  - IDLE_HELD (busy=0, pending=1), transient, lasts exactly one cycle.
- Latency: val_in at edge k gives val_start high during cycle k+1. The controller then presents addr=0 from cycle k+2, and data_out is valid one cycle after each addr.
- Widths: pointers and the index are log2(Num_coef) bits (5 for 17), using the same ceiling-log2 function as the controller.

Decomposition:
- Shared package: ceiling-log2 function, Num_coef and Data_width defaults, and the reset polarity constant (active-low).
- One natural sub-module: circ_index, the combinational modulo subtractor (newest, addr -> index).
- Storage is a register array, not RAM, because of the zero clear on reset.

Test Plan:
- Reset then a single val_in with data_in=100 -> val_start pulses 1 cycle later. Sweeping addr 0..16 gives data_out 100,0,0,...,0, each one cycle after its addr.
- 20 back-to-back passes with samples 1..20, each sent after done_in -> on pass 20, addr 0..16 returns 20,19,...,4 (wrap exercised at wr_ptr 16->0).
- val_in=7 while busy -> pending=1. done_in pulse -> val_start 2 cycles after done_in, pending=0, addr=0 returns 7.
- Two val_in (8 then 9) during one busy pass -> overrun=1, sample 9 committed, 8 lost. overrun_clr -> overrun=0. overrun_clr coincident with a third held overwrite -> overrun stays 1.
- Assert rst=0 asynchronously mid-pass with pending=1 -> every output is 0 immediately (before the next clock edge), and all addr reads return 0 after release.
- addr=17 (out of range) -> data_out=0.

Source files
------------

// File: rtl/sample_delay_line_pkg.sv
// Shared constants and helpers for the FIR input delay line.
// The reset polarity constant documents the active-low asynchronous reset used throughout.
package sample_delay_line_pkg;

    localparam int   NUM_COEF_DEF   = 17;
    localparam int   DATA_WIDTH_DEF = 12;
    localparam logic RST_ACTIVE     = 1'b0;

    // Ceiling log2; the FIR controller uses the same function for its tap address.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_delay_line_if.sv
// Sample/tap bus between the upstream source, the FIR controller and the delay line.
// The master side drives samples and tap addresses; the slave side is the delay line.
interface sample_delay_line_if
    import sample_delay_line_pkg::*;
#(
    parameter int Num_coef   = NUM_COEF_DEF,
    parameter int Data_width = DATA_WIDTH_DEF,
    parameter int Addr_width = clog2(Num_coef)
);

    logic                         val_in;
    logic signed [Data_width-1:0] data_in;
    logic        [Addr_width-1:0] addr;
    logic                         done_in;
    logic                         overrun_clr;
    logic signed [Data_width-1:0] data_out;
    logic                         val_start;
    logic                         busy;
    logic                         pending;
    logic                         overrun;

    modport master (
        output val_in, data_in, addr, done_in, overrun_clr,
        input  data_out, val_start, busy, pending, overrun
    );

    modport slave (
        input  val_in, data_in, addr, done_in, overrun_clr,
        output data_out, val_start, busy, pending, overrun
    );

endinterface

// File: rtl/sample_delay_line_circ_index.sv
// Modulo subtractor mapping a tap address onto the circular buffer slot:
// index = (newest - addr) mod Num_coef, done with a compare and one add instead of a divider.
module sample_delay_line_circ_index
    import sample_delay_line_pkg::*;
#(
    parameter int Num_coef   = NUM_COEF_DEF,
    parameter int Addr_width = clog2(Num_coef)
) (
    input  logic [Addr_width-1:0] newest_i,
    input  logic [Addr_width-1:0] addr_i,
    output logic [Addr_width-1:0] index_o
);

    logic [Addr_width:0] wrap_sum_s;

    // One extra bit keeps newest + Num_coef - addr from overflowing before truncation.
    always_comb begin
        wrap_sum_s = {1'b0, newest_i} + (Addr_width + 1)'(Num_coef) - {1'b0, addr_i};
        if (addr_i > newest_i) begin
            index_o = wrap_sum_s[Addr_width-1:0];
        end else begin
            index_o = newest_i - addr_i;
        end
    end

endmodule

// File: rtl/sample_delay_line.sv
// Circular Num_coef-deep sample delay line feeding the serial FIR MAC: commits samples,
// pulses the controller start, holds one sample during a pass and returns x[n-addr] registered.
module sample_delay_line
    import sample_delay_line_pkg::*;
#(
    parameter int Num_coef   = NUM_COEF_DEF,
    parameter int Data_width = DATA_WIDTH_DEF,
    parameter int Addr_width = clog2(Num_coef)
) (
    input logic               clk,
    input logic               rst,
    sample_delay_line_if.slave bus
);

    typedef logic signed [Data_width-1:0] sample_t;

    localparam logic [Addr_width-1:0] LAST_PTR = Addr_width'(Num_coef - 1);

    sample_t               mem_q [Num_coef];
    sample_t               mem_d [Num_coef];
    logic [Addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [Addr_width-1:0] newest_q, newest_d;
    sample_t               hold_q, hold_d;
    sample_t               data_out_q, data_out_d;
    logic                  val_start_q, val_start_d;
    logic                  busy_q, busy_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;

    logic                  commit_s;
    logic                  overrun_set_s;
    sample_t               sample_s;
    logic [Addr_width-1:0] rd_index_s;

    sample_delay_line_circ_index #(
        .Num_coef   (Num_coef),
        .Addr_width (Addr_width)
    ) u_circ_index (
        .newest_i (newest_q),
        .addr_i   (bus.addr),
        .index_o  (rd_index_s)
    );

    // Commit, hold-register and pass-tracking next state.
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        newest_d      = newest_q;
        hold_d        = hold_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        commit_s      = !busy_q && (pending_q || bus.val_in);
        sample_s      = pending_q ? hold_q : bus.data_in;
        overrun_set_s = bus.val_in && busy_q && pending_q;

        if (commit_s) begin
            mem_d[wr_ptr_q] = sample_s;
            newest_d        = wr_ptr_q;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + Addr_width'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // A new sample is held whenever it cannot commit directly; the newest always wins.
        if (bus.val_in && (busy_q || pending_q)) begin
            hold_d    = bus.data_in;
            pending_d = 1'b1;
        end else if (commit_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (overrun_set_s) begin
            overrun_d = 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        // busy drops on done_in; a commit can only start once busy is already low.
        busy_d      = busy_q ? !bus.done_in : commit_s;
        val_start_d = commit_s;
    end

    // Tap read uses pre-write contents; out-of-range addresses return zero.
    always_comb begin
        data_out_d = '0;
        if (({1'b0, bus.addr} < (Addr_width + 1)'(Num_coef)) && (rd_index_s <= LAST_PTR)) begin
            data_out_d = mem_q[rd_index_s];
        end else begin
            data_out_d = '0;
        end
    end

    // State registers; reset clears the delay line and aborts any pass in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            newest_q    <= LAST_PTR;
            hold_q      <= '0;
            data_out_q  <= '0;
            val_start_q <= 1'b0;
            busy_q      <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            newest_q    <= newest_d;
            hold_q      <= hold_d;
            data_out_q  <= data_out_d;
            val_start_q <= val_start_d;
            busy_q      <= busy_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.val_start = val_start_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sample_delay_line.sv
// Scoreboard bench for sample_delay_line: stimulus queues expected tap reads and start
// pulse cycles, a negedge monitor pops and compares them as the DUT presents them.
module tb_sample_delay_line;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    bit   rd_flag;
    bit   rd_valid_sh;
    int   exp_q[$];
    int   start_q[$];

    sample_delay_line_if #(.Num_coef(17), .Data_width(12)) bus ();

    sample_delay_line #(.Num_coef(17), .Data_width(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rd_valid_sh <= rd_flag;
    end

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares registered tap data and start pulses against the queues.
    always @(negedge clk) begin
        if (rd_valid_sh) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                check("data_out", int'(bus.data_out), exp_q.pop_front());
            end
        end
        if (bus.val_start) begin
            if (start_q.size() == 0) begin
                check("val_start_unexpected", cyc, -1);
            end else begin
                check("val_start_cycle", cyc, start_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input bit expect_start);
        bus.val_in  = 1'b1;
        bus.data_in = 12'(v);
        if (expect_start) start_q.push_back(cyc + 1);
        tick();
        bus.val_in = 1'b0;
    endtask

    task automatic done_pulse(input bit held);
        bus.done_in = 1'b1;
        if (held) start_q.push_back(cyc + 2);
        tick();
        bus.done_in = 1'b0;
    endtask

    task automatic rd(input int a, input int e);
        bus.addr = 5'(a);
        rd_flag  = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_flag = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data_out"}, int'(bus.data_out), 0);
        check({tag, "_val_start"}, int'(bus.val_start), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_pending"}, int'(bus.pending), 0);
        check({tag, "_overrun"}, int'(bus.overrun), 0);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        cyc             = 0;
        rd_flag         = 1'b0;
        rst             = 1'b0;
        bus.val_in      = 1'b0;
        bus.data_in     = '0;
        bus.addr        = '0;
        bus.done_in     = 1'b0;
        bus.overrun_clr = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst = 1'b1;
        tick();

        // Single sample after reset: only tap 0 holds data.
        send(100, 1'b1);
        check("busy_after_commit", int'(bus.busy), 1);
        for (int a = 0; a < 17; a++) rd(a, (a == 0) ? 100 : 0);
        done_pulse(1'b0);
        check("busy_after_done", int'(bus.busy), 0);

        // Back-to-back passes; the write pointer wraps 16 -> 0 along the way.
        for (int s = 1; s <= 19; s++) begin
            send(s, 1'b1);
            done_pulse(1'b0);
        end
        send(20, 1'b1);
        for (int a = 0; a < 17; a++) rd(a, 20 - a);

        // Sample arriving during a pass is held, then commits two cycles after done_in.
        send(7, 1'b0);
        check("held_pending", int'(bus.pending), 1);
        check("held_busy", int'(bus.busy), 1);
        done_pulse(1'b1);
        check("idle_held_busy", int'(bus.busy), 0);
        check("idle_held_pending", int'(bus.pending), 1);
        tick();
        check("held_commit_pending", int'(bus.pending), 0);
        check("held_commit_busy", int'(bus.busy), 1);
        rd(0, 7);
        rd(1, 20);

        // Overwrite of a held sample sets overrun; newest sample wins.
        send(8, 1'b0);
        check("one_held_overrun", int'(bus.overrun), 0);
        send(9, 1'b0);
        check("overwrite_overrun", int'(bus.overrun), 1);
        done_pulse(1'b1);
        tick();
        rd(0, 9);
        rd(1, 7);
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        check("overrun_cleared", int'(bus.overrun), 0);
        send(10, 1'b0);
        check("refill_no_overrun", int'(bus.overrun), 0);
        bus.overrun_clr = 1'b1;
        send(11, 1'b0);
        bus.overrun_clr = 1'b0;
        check("set_beats_clear", int'(bus.overrun), 1);
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        check("overrun_cleared2", int'(bus.overrun), 0);

        // Held sample commits while a new one refills the hold register in the same edge.
        done_pulse(1'b1);
        send(12, 1'b0);
        check("refill_pending", int'(bus.pending), 1);
        check("refill_overrun", int'(bus.overrun), 0);
        check("refill_busy", int'(bus.busy), 1);
        rd(0, 11);
        rd(1, 9);
        done_pulse(1'b1);
        tick();
        rd(0, 12);
        rd(1, 11);

        // Asynchronous reset mid-pass with a held sample and overrun set.
        send(13, 1'b0);
        send(14, 1'b0);
        check("pre_rst_overrun", int'(bus.overrun), 1);
        check("pre_rst_pending", int'(bus.pending), 1);
        bus.addr = 5'd0;
        tick();
        check("pre_rst_data", int'(bus.data_out), 12);
        #1;
        rst = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        tick();
        tick();
        rst = 1'b1;
        tick();
        for (int a = 0; a < 17; a++) rd(a, 0);

        // Out-of-range tap addresses read as zero.
        send(55, 1'b1);
        tick();
        rd(0, 55);
        rd(17, 0);
        rd(31, 0);
        rd(1, 0);

        repeat (3) tick();
        check("exp_q_drained", exp_q.size(), 0);
        check("start_q_drained", start_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
